vga_sync_gen: RTL

Raster timing generator for the VGA display path. Divides the 100 MHz system clock into a pixel tick and runs horizontal and vertical counters for 640x480@60 timing. From these it produces active-low hsync and vsync, an active-video flag, the pixel coordinates and a frame-start pulse. It sits directly upstream of the pixel/colour stage that drives the 12-bit `out` bus in `top_vga`. That stage consumes `x`, `y`, `active` and `pix_tick`; the sync outputs go straight to the pins.

---
 rtl/vga_sync_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: pixel-tick divider, h/v counters, registered sync/active/position.
// Optional colour-bar test pattern on rgb when VGA_SYNC_GEN_TESTPAT_EN is defined.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             advance;
  logic [9:0]       nx;
  logic [9:0]       ny;
  logic             n_active;

  // Outputs are decoded from the next position so they land together on the advance edge.
  always_comb begin
    advance = (div == DIV_LAST);
    nx      = x + 1'b1;
    ny      = y;
    if (x == H_LAST) begin
      nx = '0;
      ny = (y == V_LAST) ? '0 : y + 1'b1;
    end
    n_active = (nx < H_VIS) && (ny < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= advance;
      frame_start <= advance && (nx == '0) && (ny == '0);
      div         <= advance ? '0 : div + 1'b1;
      if (advance) begin
        x      <= nx;
        y      <= ny;
        hsync  <= !((nx >= HS_START) && (nx < HS_END));
        vsync  <= !((ny >= VS_START) && (ny < VS_END));
        active <= n_active;
      end
    end
  end

`ifdef VGA_SYNC_GEN_TESTPAT_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [11:0] n_rgb;

  always_comb begin
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (nx >= 10'(i * BAR_W)) bar = 3'(i);
    end
    case (bar)
      3'd0:    n_rgb = 12'hFFF;
      3'd1:    n_rgb = 12'hFF0;
      3'd2:    n_rgb = 12'h0FF;
      3'd3:    n_rgb = 12'h0F0;
      3'd4:    n_rgb = 12'hF0F;
      3'd5:    n_rgb = 12'hF00;
      3'd6:    n_rgb = 12'h00F;
      default: n_rgb = 12'h000;
    endcase
    if (!n_active) n_rgb = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (advance) begin
      rgb <= n_rgb;
    end
  end
`else
  assign rgb = '0;
`endif

endmodule
